// File: rtl/spi_slot_gpio_ctrl_if.sv
// SPI slave pin bundle between the slot GPIO controller and whatever drives its SPI pins.
// The slave side samples SCK/CS/MOSI and drives MISO.
interface spi_slot_gpio_ctrl_if;
    logic spi_clk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_clk,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_clk,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/spi_slot_gpio_ctrl.sv
// SPI-slave register bank driving NUM_SLOTS bidirectional slot ports with per-slot
// output/direction/input/mask/pending registers; SPI pins are oversampled on sys_clk.
module spi_slot_gpio_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int DUMMY_CYCLES = 6,
    parameter int NUM_SLOTS    = 8
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    spi_slot_gpio_ctrl_if.slave         spi,
    input  logic [NUM_SLOTS*DATA_W-1:0] slot_i,
    output logic [NUM_SLOTS*DATA_W-1:0] slot_o,
    output logic [NUM_SLOTS*DATA_W-1:0] slot_oe,
    output logic                        irq
);
    localparam int MAX_A_D = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAX_LEN = (MAX_A_D > DUMMY_CYCLES) ? MAX_A_D : DUMMY_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE
    } state_t;

    // Reset: asynchronous assertion, release synchronised to sys_clk.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Pin synchronisers: [1] is the synced value, [2] the previous one for edge detection.
    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;
    logic [NUM_SLOTS-1:0][DATA_W-1:0] in_meta_q;
    logic [NUM_SLOTS-1:0][DATA_W-1:0] in_sync_q;
    logic [NUM_SLOTS-1:0][DATA_W-1:0] in_prev_q;

    // cs chain resets low so a frame already in progress at reset release shows no falling
    // edge; the FSM then waits for cs_n to rise and fall again.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q     <= '0;
            cs_q      <= '0;
            mosi_q    <= '0;
            in_meta_q <= '0;
            in_sync_q <= '0;
            in_prev_q <= '0;
        end else begin
            sck_q     <= {sck_q[1:0], spi.spi_clk};
            cs_q      <= {cs_q[1:0], spi.spi_cs_n};
            mosi_q    <= {mosi_q[0], spi.spi_mosi};
            in_meta_q <= slot_i;
            in_sync_q <= in_meta_q;
            in_prev_q <= in_sync_q;
        end
    end

    logic sck_rise;
    logic sck_fall;
    logic cs_fall;
    logic cs_rise;
    logic mosi_s;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign mosi_s   = mosi_q[1];

    // Frame state and slot registers.
    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [DATA_W-2:0]                data_q, data_d;
    logic [DATA_W-1:0]                rd_q, rd_d;
    logic                             miso_q, miso_d;
    logic [NUM_SLOTS-1:0][DATA_W-1:0] out_q, out_d;
    logic [NUM_SLOTS-1:0][DATA_W-1:0] dir_q, dir_d;
    logic [NUM_SLOTS-1:0][DATA_W-1:0] mask_q, mask_d;
    logic [NUM_SLOTS-1:0][DATA_W-1:0] pend_q, pend_d;
    logic [NUM_SLOTS-1:0][DATA_W-1:0] clr;
    logic                             irq_q;

    logic [ADDR_W-1:0] addr_shift;
    logic [DATA_W-1:0] data_shift;
    logic [2:0]        rd_grp;
    logic [NUM_SLOTS-1:0] rd_hit;
    logic [NUM_SLOTS-1:0] wr_hit;
    logic [DATA_W-1:0] slot_rd [NUM_SLOTS];
    logic [DATA_W-1:0] rd_word;
    logic              wr_en;

    assign addr_shift = {addr_q[ADDR_W-2:0], mosi_s};
    assign data_shift = {data_q, mosi_s};
    assign rd_grp     = addr_shift[5:3];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign rd_hit[gi] = (addr_shift[2:0] == 3'(gi));
            assign wr_hit[gi] = (addr_q[2:0] == 3'(gi));

            // Read source for this slot, decoded from the address as it completes.
            assign slot_rd[gi] = !rd_hit[gi]     ? '0 :
                                 (rd_grp == 3'd0) ? out_q[gi] :
                                 (rd_grp == 3'd1) ? in_sync_q[gi] :
                                 (rd_grp == 3'd2) ? dir_q[gi] :
                                 (rd_grp == 3'd4) ? mask_q[gi] :
                                 (rd_grp == 3'd5) ? pend_q[gi] :
                                 (rd_grp == 3'd6) ? pend_q[gi] : '0;

            // A fresh edge on a masked pin beats a simultaneous clear.
            assign pend_d[gi] = (pend_q[gi] & ~clr[gi])
                              | ((in_sync_q[gi] ^ in_prev_q[gi]) & mask_q[gi]);
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            rd_word = rd_word | slot_rd[s];
        end
    end

    // Frame FSM; MISO changes only on SCK falls (or cs_n edges) so the master samples it stable.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_d    = rd_q;
        miso_d  = miso_q;
        wr_en   = 1'b0;
        if (cs_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end else if (cs_fall) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (sck_rise) begin
                        addr_d = addr_shift;
                        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                            state_d = ST_DUMMY;
                            cnt_d   = '0;
                            rd_d    = rd_word;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (sck_fall) begin
                        miso_d = addr_q[0];
                    end
                end
                ST_DUMMY: begin
                    if (sck_rise) begin
                        if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                            state_d = ST_DATA;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (sck_fall) begin
                        // The first dummy fall still echoes the last address bit.
                        miso_d = (cnt_q == '0) ? addr_q[0] : 1'b0;
                    end
                end
                ST_DATA: begin
                    if (sck_rise) begin
                        data_d = data_shift[DATA_W-2:0];
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = ST_DONE;
                            wr_en   = ~addr_q[ADDR_W-1];
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (sck_fall) begin
                        miso_d = rd_q[DATA_W-1];
                        rd_d   = {rd_q[DATA_W-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    if (sck_fall) begin
                        miso_d = 1'b0;
                    end
                end
                default: begin
                    miso_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        clr    = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (wr_en && wr_hit[s]) begin
                case (addr_q[5:3])
                    3'd0:    out_d[s]  = data_shift;
                    3'd2:    dir_d[s]  = data_shift;
                    3'd4:    mask_d[s] = data_shift;
                    3'd5:    clr[s]    = data_shift;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            miso_q  <= 1'b0;
            out_q   <= '0;
            dir_q   <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            miso_q  <= miso_d;
            out_q   <= out_d;
            dir_q   <= dir_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            irq_q   <= |(pend_q & mask_q);
        end
    end

    assign slot_o       = out_q;
    assign slot_oe      = dir_q;
    assign irq          = irq_q;
    assign spi.spi_miso = miso_q;
endmodule
